// File: rtl/step_pkg.sv
// Shared types and phase-code helpers for the stepper phase decoder.
// Holds the FSM state enum, the wave-drive phase codes and neighbour functions.
// No logic of its own; imported by step_glitch_filter and step_phase_decoder.
package step_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_TRACK = 2'd1,
    ST_FAULT = 2'd2
  } state_e;

  // Wave-drive phase codes, forward order A->B->C->D->A
  localparam logic [3:0] PH_A   = 4'b1000;
  localparam logic [3:0] PH_B   = 4'b0100;
  localparam logic [3:0] PH_C   = 4'b0010;
  localparam logic [3:0] PH_D   = 4'b0001;
  // Driver disabled
  localparam logic [3:0] PH_OFF = 4'b0000;

  // Forward neighbour of a one-hot phase; PH_OFF for anything else
  function automatic logic [3:0] phase_next(input logic [3:0] p);
    case (p)
      PH_A:    return PH_B;
      PH_B:    return PH_C;
      PH_C:    return PH_D;
      PH_D:    return PH_A;
      default: return PH_OFF;
    endcase
  endfunction

  // Reverse neighbour of a one-hot phase; PH_OFF for anything else
  function automatic logic [3:0] phase_prev(input logic [3:0] p);
    case (p)
      PH_A:    return PH_D;
      PH_B:    return PH_A;
      PH_C:    return PH_B;
      PH_D:    return PH_C;
      default: return PH_OFF;
    endcase
  endfunction

  function automatic logic is_onehot(input logic [3:0] p);
    return (p == PH_A) || (p == PH_B) || (p == PH_C) || (p == PH_D);
  endfunction

endpackage

// File: rtl/step_glitch_filter.sv
// 2-flop synchronizer plus stability counter for the raw coil drive signals.
// Latency: code_valid pulses FILT_CYCLES+2 edges after a new value is first sampled.
// No backpressure: code_valid is a one-cycle pulse, once per newly stable code.
module step_glitch_filter
  import step_pkg::*;
#(
  parameter int FILT_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] phase_in,
  output logic       code_valid,
  output logic [3:0] code
);

  localparam logic [3:0] FILT_N = 4'(FILT_CYCLES);

  logic [3:0] sync1_q, sync2_q;
  logic [3:0] last_q;
  logic [3:0] cnt_q, cnt_d;
  logic       vld_q, vld_d;
  logic [3:0] code_q;

  // Count consecutive identical synchronized samples; fire once when a run first reaches FILT_N
  always_comb begin
    cnt_d = cnt_q;
    if (sync2_q != last_q) begin
      cnt_d = 4'd1;
    end else if (cnt_q != FILT_N) begin
      cnt_d = cnt_q + 4'd1;
    end
    // A run already at FILT_N that continues must not fire again
    vld_d = (cnt_d == FILT_N) && !((sync2_q == last_q) && (cnt_q == FILT_N));
  end

  // Synchronizer, run tracker and output pulse registers
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= PH_OFF;
      sync2_q <= PH_OFF;
      last_q  <= PH_OFF;
      cnt_q   <= 4'd0;
      vld_q   <= 1'b0;
      code_q  <= PH_OFF;
    end else begin
      sync1_q <= phase_in;
      sync2_q <= sync1_q;
      last_q  <= sync2_q;
      cnt_q   <= cnt_d;
      vld_q   <= vld_d;
      if (vld_d) begin
        code_q <= sync2_q;
      end
    end
  end

  assign code_valid = vld_q;
  assign code       = code_q;

endmodule

// File: rtl/step_phase_decoder.sv
// Stepper phase decoder: filters coil drive codes and tracks a signed step position.
// Latency: FILT_CYCLES+3 edges from first sampling a new phase to step_pulse/position.
// No backpressure; optional stall detector enabled by macro STEP_STALL_DETECT_EN.
module step_phase_decoder
  import step_pkg::*;
#(
  parameter int POS_W        = 16,
  parameter int FILT_CYCLES  = 4,
  parameter int STALL_CYCLES = 1000000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [3:0]              phase_in,
  input  logic                    clr,
  output logic signed [POS_W-1:0] position,
  output logic                    dir_out,
  output logic                    step_pulse,
  output logic                    fault,
  output logic                    stall
);

  if (FILT_CYCLES < 1 || FILT_CYCLES > 15 || STALL_CYCLES < 1) begin : g_param_check
    $error("step_phase_decoder: FILT_CYCLES must be 1..15 and STALL_CYCLES >= 1");
  end

  logic       filt_vld;
  logic [3:0] filt_code;

  step_glitch_filter #(
    .FILT_CYCLES(FILT_CYCLES)
  ) u_filter (
    .clk       (clk),
    .rst       (rst),
    .phase_in  (phase_in),
    .code_valid(filt_vld),
    .code      (filt_code)
  );

  state_e           state_q, state_d;
  logic [3:0]       ref_q, ref_d;
  logic [POS_W-1:0] pos_q, pos_d;
  logic             dir_q, dir_d;
  logic             pulse_q, pulse_d;
  logic             fault_q, fault_d;

  // Classification of the accepted code against the reference phase.
  // A step right after another step is dropped so step_pulse never repeats
  // back to back; this only happens with FILT_CYCLES=1 and a phase changing every cycle.
  logic trk_vld, go_lock, go_fwd, go_rev, go_off, go_bad, is_known;

  assign trk_vld  = filt_vld && !clr && (state_q == ST_TRACK);
  assign is_known = (filt_code == ref_q) || (filt_code == phase_next(ref_q)) ||
                    (filt_code == phase_prev(ref_q)) || (filt_code == PH_OFF);
  assign go_fwd   = trk_vld && !pulse_q && (filt_code == phase_next(ref_q));
  assign go_rev   = trk_vld && !pulse_q && (filt_code == phase_prev(ref_q));
  assign go_off   = trk_vld && (filt_code == PH_OFF);
  assign go_bad   = trk_vld && !is_known;
  // Illegal codes seen in IDLE are ignored; only a one-hot code starts tracking
  assign go_lock  = filt_vld && !clr && (state_q == ST_IDLE) && is_onehot(filt_code);

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic; clr outranks everything, FAULT waits for clr
  always_comb begin
    state_d = state_q;
    if (clr) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:  if (go_lock) state_d = ST_TRACK;
        ST_TRACK: begin
          if (go_off) begin
            state_d = ST_IDLE;
          end else if (go_bad) begin
            state_d = ST_FAULT;
          end
        end
        ST_FAULT: state_d = ST_FAULT;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  // FSM outputs: next values for position, direction, pulse, fault and reference phase
  always_comb begin
    pos_d   = pos_q;
    dir_d   = dir_q;
    pulse_d = 1'b0;
    fault_d = fault_q;
    ref_d   = ref_q;
    if (clr) begin
      pos_d   = '0;
      fault_d = 1'b0;
      ref_d   = PH_OFF;
    end else begin
      if (go_lock) begin
        ref_d = filt_code;
      end
      if (go_fwd) begin
        pos_d   = pos_q + POS_W'(1);
        dir_d   = 1'b1;
        pulse_d = 1'b1;
        ref_d   = filt_code;
      end
      if (go_rev) begin
        pos_d   = pos_q - POS_W'(1);
        dir_d   = 1'b0;
        pulse_d = 1'b1;
        ref_d   = filt_code;
      end
      if (go_bad) begin
        fault_d = 1'b1;
      end
    end
  end

  // Output and reference-phase registers
  always_ff @(posedge clk) begin
    if (rst) begin
      pos_q   <= '0;
      dir_q   <= 1'b1;
      pulse_q <= 1'b0;
      fault_q <= 1'b0;
      ref_q   <= PH_OFF;
    end else begin
      pos_q   <= pos_d;
      dir_q   <= dir_d;
      pulse_q <= pulse_d;
      fault_q <= fault_d;
      ref_q   <= ref_d;
    end
  end

  assign position   = $signed(pos_q);
  assign dir_out    = dir_q;
  assign step_pulse = pulse_q;
  assign fault      = fault_q;

`ifdef STEP_STALL_DETECT_EN
  localparam int SC_W = $clog2(STALL_CYCLES + 1);
  localparam logic [SC_W-1:0] STALL_N = SC_W'(STALL_CYCLES);

  logic [SC_W-1:0] scnt_q, scnt_d;
  logic            stall_q, stall_d;

  // Idle-cycle counter: runs only while staying in TRACK without a step, saturates at STALL_N
  always_comb begin
    scnt_d  = '0;
    stall_d = stall_q;
    if (clr || pulse_d) begin
      stall_d = 1'b0;
    end
    if (!clr && !pulse_d && (state_q == ST_TRACK) && (state_d == ST_TRACK)) begin
      scnt_d = (scnt_q == STALL_N) ? scnt_q : scnt_q + SC_W'(1);
    end
    if (scnt_d == STALL_N) begin
      stall_d = 1'b1;
    end
  end

  // Stall counter and flag registers
  always_ff @(posedge clk) begin
    if (rst) begin
      scnt_q  <= '0;
      stall_q <= 1'b0;
    end else begin
      scnt_q  <= scnt_d;
      stall_q <= stall_d;
    end
  end

  assign stall = stall_q;
`else
  assign stall = 1'b0;
`endif

endmodule
